// File: rtl/uart_tx.sv
// UART transmitter: valid/ready write port into a FIFO that drains frame by frame
// into a bit-timed shift engine driving a registered, idle-high serial line.
module uart_tx #(
   parameter int ClockFreqHz  = 10000000,
   parameter int BaudRate     = 9600,
   parameter int DataBitsSize = 8,
   parameter int ParityBit    = 0,
   parameter int StopBitsSize = 1,
   parameter int FifoDepth    = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_valid,
   input  logic [7:0]                   wr_data,
   output logic                         wr_ready,
   output logic                         tx_sig,
   output logic                         busy,
   output logic [$clog2(FifoDepth):0]   fifo_count
);

   localparam int SClkPeriod = ClockFreqHz / BaudRate;
   localparam int CntW       = $clog2(SClkPeriod);
   localparam int AddrW      = $clog2(FifoDepth);
   localparam logic [CntW-1:0] LastClk  = CntW'(SClkPeriod - 1);
   localparam logic [2:0]      LastData = 3'(DataBitsSize - 1);
   localparam logic [2:0]      LastStop = 3'(StopBitsSize - 1);
   localparam logic [7:0]      DataMask = 8'((16'd1 << DataBitsSize) - 16'd1);
   localparam logic [AddrW:0]  Full     = (AddrW + 1)'(FifoDepth);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t            state;
   logic [7:0]        mem [FifoDepth];
   logic [AddrW-1:0]  wr_ptr;
   logic [AddrW-1:0]  rd_ptr;
   logic [CntW-1:0]   clk_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg;
   logic              par;
   logic              push;
   logic              load;
   logic              bit_end;
   logic [7:0]        head;

   // Handshake: a byte is taken on any rising edge where wr_valid && wr_ready;
   // wr_ready depends only on the registered count, so a pop on the same edge
   // never frees a slot for a write to a full FIFO.
   assign wr_ready = fifo_count < Full;
   assign push     = wr_valid && wr_ready;
   assign bit_end  = clk_cnt == LastClk;
   assign head     = mem[rd_ptr] & DataMask;
   assign load     = (fifo_count != '0) &&
                     ((state == IDLE) || (state == STOP && bit_end && bit_cnt == LastStop));
   assign busy     = (state != IDLE) || (fifo_count != '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load) rd_ptr <= rd_ptr + 1'b1;
         case ({push, load})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx_sig  <= 1'b1;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
      end else begin
         clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
         case (state)
            IDLE: begin
               tx_sig  <= 1'b1;
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (load) begin
                  shreg  <= head;
                  par    <= ^head;
                  tx_sig <= 1'b0;
                  state  <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  tx_sig  <= shreg[0];
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == LastData) begin
                     bit_cnt <= '0;
                     if (ParityBit != 0) begin
                        tx_sig <= par;
                        state  <= PARITY;
                     end else begin
                        tx_sig <= 1'b1;
                        state  <= STOP;
                     end
                  end else begin
                     // shreg[0] is the bit on the line; shift to expose the next one
                     shreg   <= shreg >> 1;
                     tx_sig  <= shreg[1];
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  tx_sig  <= 1'b1;
                  bit_cnt <= '0;
                  state   <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (bit_cnt == LastStop) begin
                     bit_cnt <= '0;
                     if (load) begin
                        shreg  <= head;
                        par    <= ^head;
                        tx_sig <= 1'b0;
                        state  <= START;
                     end else begin
                        tx_sig <= 1'b1;
                        state  <= IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: begin
               tx_sig  <= 1'b1;
               clk_cnt <= '0;
               bit_cnt <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E1, 8N2) at 10 clocks per bit share one
// write bus; a line monitor decodes frames of the selected instance against a byte queue.
module tb_uart_tx;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data  = 8'h00;

   logic       rdy_a, tx_a, busy_a;
   logic       rdy_p, tx_p, busy_p;
   logic       rdy_s, tx_s, busy_s;
   logic [4:0] cnt_a, cnt_p, cnt_s;

   uart_tx #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(8),
             .ParityBit(0), .StopBitsSize(1), .FifoDepth(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(rdy_a), .tx_sig(tx_a), .busy(busy_a), .fifo_count(cnt_a));

   uart_tx #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(8),
             .ParityBit(1), .StopBitsSize(1), .FifoDepth(16)) dut_p (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(rdy_p), .tx_sig(tx_p), .busy(busy_p), .fifo_count(cnt_p));

   uart_tx #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBitsSize(8),
             .ParityBit(0), .StopBitsSize(2), .FifoDepth(16)) dut_s (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(rdy_s), .tx_sig(tx_s), .busy(busy_s), .fifo_count(cnt_s));

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         vectors     = 0;
   int         miscompares = 0;
   int         sel         = 0;
   int         frames_done = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];

   logic       tx_sel, rdy_sel, busy_sel;
   logic [4:0] cnt_sel;

   always_comb begin
      tx_sel = tx_a; rdy_sel = rdy_a; busy_sel = busy_a; cnt_sel = cnt_a;
      if (sel == 1) begin
         tx_sel = tx_p; rdy_sel = rdy_p; busy_sel = busy_p; cnt_sel = cnt_p;
      end else if (sel == 2) begin
         tx_sel = tx_s; rdy_sel = rdy_s; busy_sel = busy_s; cnt_sel = cnt_s;
      end
   end

   // line monitor / scoreboard: every slot must hold its value for all 10 clocks
   initial begin : monitor
      logic [7:0] d;
      logic       expb [12];
      int         nslots;
      int         st;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx_sel === 1'b0) begin
            st     = cyc;
            nslots = 10 + ((sel == 1) ? 1 : 0) + ((sel == 2) ? 1 : 0);
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL frame_unexpected: frame started at cycle %0d, required no frame", st);
               d = 8'h00;
            end else begin
               d = exp_q.pop_front();
            end
            expb[0] = 1'b0;
            for (int i = 0; i < 8; i++) expb[i+1] = d[i];
            expb[9]  = (sel == 1) ? ^d : 1'b1;
            expb[10] = 1'b1;
            expb[11] = 1'b1;
            aborted  = 1'b0;
            for (int s = 0; s < nslots && !aborted; s++) begin
               logic bad;
               logic seen;
               bad  = 1'b0;
               seen = expb[s];
               for (int c = 0; c < 10; c++) begin
                  if (!(s == 0 && c == 0)) @(negedge clk);
                  if (rst_n !== 1'b1) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (tx_sel !== expb[s]) begin
                     bad  = 1'b1;
                     seen = tx_sel;
                  end
               end
               if (!aborted) begin
                  vectors++;
                  if (bad) begin
                     miscompares++;
                     $display("FAIL frame_bit slot %0d byte %02h: tx_sig=%b, required %b for 10 clocks",
                              s, d, seen, expb[s]);
                  end
               end
            end
            if (!aborted) begin
               start_q.push_back(st);
               frames_done++;
            end
         end
      end
   end

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      repeat (3) @(negedge clk);
      exp_q.delete();
      start_q.delete();
      frames_done = 0;
      rst_n = 1'b1;
   endtask

   task automatic write_byte(input logic [7:0] d, output bit acc, output int n);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = d;
      acc      = rdy_sel;
      n        = cyc + 1;
      @(posedge clk);
      if (acc) exp_q.push_back(d);
   endtask

   task automatic idle_bus();
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_frames(input int k, input int budget, input string name);
      int t;
      t = 0;
      while (frames_done < k && t < budget) begin
         @(negedge clk);
         t++;
      end
      vectors++;
      if (frames_done < k) begin
         miscompares++;
         $display("FAIL %s timeout: %0d frames seen, required %0d", name, frames_done, k);
      end
   endtask

   task automatic check_starts(input int exp_first, input int spacing, input int k, input string name);
      int st;
      for (int i = 0; i < k; i++) begin
         st = (start_q.size() > 0) ? start_q.pop_front() : -1;
         vectors++;
         if (st !== exp_first + i * spacing) begin
            miscompares++;
            $display("FAIL %s start %0d: cycle %0d, required %0d", name, i, st, exp_first + i * spacing);
         end
      end
   endtask

   // scenarios
   task automatic test_reset();
      sel = 0;
      do_reset();
      @(negedge clk);
      vectors++; if (tx_a !== 1'b1)   begin miscompares++; $display("FAIL reset_tx: %b, required 1", tx_a); end
      vectors++; if (rdy_a !== 1'b1)  begin miscompares++; $display("FAIL reset_ready: %b, required 1", rdy_a); end
      vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy: %b, required 0", busy_a); end
      vectors++; if (cnt_a !== 5'd0)  begin miscompares++; $display("FAIL reset_count: %0d, required 0", cnt_a); end
      vectors++; if (tx_p !== 1'b1)   begin miscompares++; $display("FAIL reset_tx_parity: %b, required 1", tx_p); end
      vectors++; if (tx_s !== 1'b1)   begin miscompares++; $display("FAIL reset_tx_stop2: %b, required 1", tx_s); end
   endtask

   task automatic test_single();
      bit acc;
      int n;
      sel = 0;
      do_reset();
      write_byte(8'h55, acc, n);
      idle_bus();
      vectors++; if (tx_sel !== 1'b1)   begin miscompares++; $display("FAIL single_edge_n_tx: %b, required 1", tx_sel); end
      vectors++; if (busy_sel !== 1'b1) begin miscompares++; $display("FAIL single_busy_queued: %b, required 1", busy_sel); end
      wait_until(n + 1);
      vectors++; if (tx_sel !== 1'b0)   begin miscompares++; $display("FAIL single_start_latency: %b, required 0", tx_sel); end
      wait_until(n + 100);
      vectors++; if (busy_sel !== 1'b1) begin miscompares++; $display("FAIL single_busy_stop: %b, required 1", busy_sel); end
      wait_until(n + 101);
      vectors++; if (busy_sel !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: %b, required 0", busy_sel); end
      vectors++; if (tx_sel !== 1'b1)   begin miscompares++; $display("FAIL single_idle_tx: %b, required 1", tx_sel); end
      wait_frames(1, 50, "single");
      check_starts(n + 1, 100, 1, "single");
   endtask

   task automatic test_back_to_back();
      bit acc;
      int n;
      int dummy;
      sel = 0;
      do_reset();
      write_byte(8'h41, acc, n);
      write_byte(8'h42, acc, dummy);
      write_byte(8'h43, acc, dummy);
      idle_bus();
      vectors++; if (cnt_sel !== 5'd2) begin miscompares++; $display("FAIL b2b_count_fill: %0d, required 2", cnt_sel); end
      wait_until(n + 101);
      vectors++; if (cnt_sel !== 5'd1) begin miscompares++; $display("FAIL b2b_count_frame2: %0d, required 1", cnt_sel); end
      wait_until(n + 201);
      vectors++; if (cnt_sel !== 5'd0) begin miscompares++; $display("FAIL b2b_count_frame3: %0d, required 0", cnt_sel); end
      wait_frames(3, 300, "b2b");
      check_starts(n + 1, 100, 3, "b2b");
      wait_until(n + 301);
      vectors++; if (busy_sel !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end: %b, required 0", busy_sel); end
   endtask

   task automatic test_fifo_full();
      bit acc;
      int n;
      int accepted;
      sel = 0;
      do_reset();
      accepted = 0;
      for (int i = 0; i < 20; i++) begin
         write_byte(8'(8'h10 + i), acc, n);
         if (acc) accepted++;
      end
      idle_bus();
      vectors++; if (accepted !== 17)   begin miscompares++; $display("FAIL full_accepted: %0d, required 17", accepted); end
      vectors++; if (cnt_sel !== 5'd16) begin miscompares++; $display("FAIL full_count: %0d, required 16", cnt_sel); end
      vectors++; if (rdy_sel !== 1'b0)  begin miscompares++; $display("FAIL full_ready: %b, required 0", rdy_sel); end
      wait_frames(17, 2000, "full");
      vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL full_drained: %0d left, required 0", exp_q.size()); end
      repeat (150) @(negedge clk);
      vectors++; if (frames_done !== 17) begin miscompares++; $display("FAIL full_no_extra: %0d frames, required 17", frames_done); end
      vectors++; if (busy_sel !== 1'b0)  begin miscompares++; $display("FAIL full_busy_end: %b, required 0", busy_sel); end
      start_q.delete();
   endtask

   task automatic test_parity();
      bit acc;
      int n;
      int dummy;
      sel = 1;
      do_reset();
      write_byte(8'h07, acc, n);
      write_byte(8'h03, acc, dummy);
      idle_bus();
      wait_frames(2, 400, "parity");
      check_starts(n + 1, 110, 2, "parity");
   endtask

   task automatic test_stop2();
      bit acc;
      int n;
      int dummy;
      sel = 2;
      do_reset();
      write_byte(8'h3C, acc, n);
      write_byte(8'hC3, acc, dummy);
      idle_bus();
      wait_frames(2, 400, "stop2");
      check_starts(n + 1, 110, 2, "stop2");
   endtask

   task automatic test_reset_mid();
      bit acc;
      int n;
      int dummy;
      sel = 0;
      do_reset();
      write_byte(8'hF0, acc, n);
      write_byte(8'h77, acc, dummy);
      idle_bus();
      wait_until(n + 45);
      vectors++; if (tx_sel !== 1'b0) begin miscompares++; $display("FAIL midreset_bit3_low: %b, required 0", tx_sel); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (tx_sel !== 1'b1)   begin miscompares++; $display("FAIL midreset_tx: %b, required 1", tx_sel); end
      vectors++; if (busy_sel !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: %b, required 0", busy_sel); end
      vectors++; if (cnt_sel !== 5'd0)  begin miscompares++; $display("FAIL midreset_count: %0d, required 0", cnt_sel); end
      vectors++; if (rdy_sel !== 1'b1)  begin miscompares++; $display("FAIL midreset_ready: %b, required 1", rdy_sel); end
      repeat (2) @(negedge clk);
      exp_q.delete();
      start_q.delete();
      frames_done = 0;
      rst_n = 1'b1;
      write_byte(8'hA5, acc, n);
      idle_bus();
      wait_frames(1, 200, "midreset_after");
      check_starts(n + 1, 100, 1, "midreset_after");
      wait_until(n + 105);
      vectors++; if (busy_sel !== 1'b0)  begin miscompares++; $display("FAIL midreset_idle_after: %b, required 0", busy_sel); end
      vectors++; if (frames_done !== 1)  begin miscompares++; $display("FAIL midreset_discard: %0d frames, required 1", frames_done); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fifo_full();
      test_parity();
      test_stop2();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at 1000000, required earlier finish");
      $fatal(1, "watchdog expired");
   end

endmodule
